// File: rtl/shift_frame_pkg.sv
// Shared state encoding, direction names and sizing helper for shift_frame_tx.
// Build option: SHIFT_FRAME_TX_PARITY_EN adds a PARITY state (and widens the state field).
package shift_frame_pkg;

`ifdef SHIFT_FRAME_TX_PARITY_EN
  localparam int unsigned STATE_W = 3;
`else
  localparam int unsigned STATE_W = 2;
`endif

  typedef enum logic [STATE_W-1:0] {
    IDLE   = STATE_W'(0),
    START  = STATE_W'(1),
    DATA   = STATE_W'(2),
    STOP   = STATE_W'(3)
`ifdef SHIFT_FRAME_TX_PARITY_EN
    , PARITY = STATE_W'(4)
`endif
  } state_e;

  localparam string DIR_LEFT  = "LEFT";
  localparam string DIR_RIGHT = "RIGHT";

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/shift_frame_tx_bit_timer.sv
// Bit-period timer: counts clocks while run=1 and flags the last cycle of each bit period.
module bit_timer
  import shift_frame_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decoded straight from the counter flop so it is stable for the whole cycle.
  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/shift_frame_tx.sv
// Framed parallel-to-serial transmitter: start bit, DATA_WIDTH data bits, stop bit.
// Build option: SHIFT_FRAME_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module shift_frame_tx
  import shift_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter string       SHIFT_DIRECTION = "RIGHT",
  parameter int unsigned BIT_CYCLES      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BIT_CNT_W = clog2(DATA_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH);
  localparam bit MSB_FIRST = (SHIFT_DIRECTION == DIR_LEFT);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef SHIFT_FRAME_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic                  tick;
  logic                  next_bit;
  logic [DATA_WIDTH-1:0] shreg_shifted;

  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (state_q != IDLE),
    .tick (tick)
  );

  // Bit order: LEFT sends the MSB first, anything else sends the LSB first.
  always_comb begin
    if (MSB_FIRST) begin
      next_bit      = shreg_q[DATA_WIDTH-1];
      shreg_shifted = {shreg_q[DATA_WIDTH-2:0], 1'b0};
    end else begin
      next_bit      = shreg_q[0];
      shreg_shifted = {1'b0, shreg_q[DATA_WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef SHIFT_FRAME_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          shreg_d    = in_data;
          bit_cnt_d  = '0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
          state_d    = START;
`ifdef SHIFT_FRAME_TX_PARITY_EN
          parity_d   = ^in_data;
`endif
        end
      end
      START: begin
        if (tick) begin
          tx_d      = next_bit;
          shreg_d   = shreg_shifted;
          bit_cnt_d = BIT_CNT_W'(1);
          state_d   = DATA;
        end
      end
      DATA: begin
        // bit_cnt_q counts bits already driven onto the line.
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef SHIFT_FRAME_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            tx_d      = next_bit;
            shreg_d   = shreg_shifted;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
`ifdef SHIFT_FRAME_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          busy_d     = 1'b0;
          in_ready_d = 1'b1;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SHIFT_FRAME_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SHIFT_FRAME_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign tx_out   = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/shift_frame_tx.md
Name: shift_frame_tx

Overview:
Framed parallel-to-serial transmitter that sits downstream of the parameterized shift register stage. It accepts a parallel word over a valid/ready handshake and emits it on a single line as a frame: one start bit (0), then DATA_WIDTH data bits, then one stop bit (1). Each bit is held for BIT_CYCLES clocks. Bit order is set by SHIFT_DIRECTION, using the same "LEFT"/"RIGHT" convention as the shift register stage.

Parameters:
DATA_WIDTH, 8, width of the parallel word (>=2)
SHIFT_DIRECTION, "RIGHT", "LEFT" = MSB first, "RIGHT" = LSB first; any other string behaves as "RIGHT"
BIT_CYCLES, 4, clocks per serial bit (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low
in_valid  input  1  in_data is valid this cycle
in_data  input  DATA_WIDTH  parallel word to transmit
in_ready  output  1  block can accept a word this cycle
tx_out  output  1  serial line, idles high
busy  output  1  frame in progress
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset and registered outputs:
  - All outputs are registered.
  - On any edge with rst=0: state=IDLE, tx_out=1, in_ready=0, busy=0, done=0, bit and cycle counters cleared.
  - First edge with rst=1 in IDLE sets in_ready=1.
- Acceptance:
  - A word is accepted on an edge where in_valid=1 and in_ready=1. in_data is captured into the internal shift register.
  - The same edge sets tx_out=0, busy=1, in_ready=0, state=START.
  - in_valid and in_data are ignored while in_ready=0.
- States:
  - IDLE: waits for acceptance.
  - START: holds tx_out=0 for BIT_CYCLES, then goes to DATA.
  - DATA: transmits DATA_WIDTH bits, BIT_CYCLES each.
    - LEFT: outputs bit [W-1], shifts left.
    - RIGHT: outputs bit [0], shifts right.
    - After the last bit, goes to STOP (or PARITY, see Optional Feature).
  - STOP: holds tx_out=1 for BIT_CYCLES, then goes to IDLE.
- Timing:
  - Acceptance edge = edge 0.
  - Start bit: edges 0..BC-1.
  - Data bit k: edges BC*(1+k) .. BC*(2+k)-1.
  - Stop bit: edges BC*(W+1) .. BC*(W+2)-1.
  - At edge BC*(W+2): state=IDLE, busy=0, in_ready=1, done=1 for exactly one cycle.
- Back-to-back frames:
  - The earliest next acceptance is edge BC*(W+2)+1.
  - The line is therefore high for BC+1 cycles between frames.
- Counters:
  - Cycle counter: width clog2(BIT_CYCLES), wraps at BIT_CYCLES-1.
  - Bit counter: width clog2(DATA_WIDTH+1).
  - BIT_CYCLES=1 is legal: one bit per clock.
- Reset mid-frame:
  - At the edge with rst=0: tx_out=1, busy=0, no done pulse, frame discarded.
  - Normal operation resumes after rst=1.

Optional Feature:
Macro: SHIFT_FRAME_TX_PARITY_EN
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - Holds the even-parity bit (XOR of the captured word) for BIT_CYCLES.
  - Frame length becomes BC*(W+3); done moves to edge BC*(W+3).
- Undefined:
  - No PARITY state and no parity logic; frame as above.

Decomposition:
- Package shift_frame_pkg holds:
  - state encoding constants IDLE/START/DATA/PARITY/STOP (2-bit field widened to 3 bits only when parity is enabled)
  - direction string constants "LEFT"/"RIGHT"
  - clog2 helper function
- Sub-module bit_timer:
  - parameter BIT_CYCLES
  - ports clk, rst, run, tick
  - tick pulses on the last cycle of each bit period
  - clears when run=0

Test Plan:
- Reset behaviour: rst=0 for 3 cycles with in_valid=1 -> tx_out=1, in_ready=0, busy=0 throughout; first edge after release -> in_ready=1, nothing accepted during reset.
- RIGHT, W=8, BC=4, in_data=0x0F -> tx_out = 0 for 4 clocks, then data bits 1,1,1,1,0,0,0,0 (4 clocks each), then 1 for 4 clocks; done=1 at edge 40 only; busy=1 for edges 0..39.
- LEFT, same stimulus 0x0F -> data bits 0,0,0,0,1,1,1,1; framing and timing identical.
- Back-to-back: in_valid held high with 0x0F then 0xF0 -> second word accepted at edge 41; tx_out high on edges 36..40; second start bit begins at edge 41.
- Busy interference: in_valid pulse with 0xFF at edge 10 of a 0x0F frame -> ignored; a single frame of 0x0F is transmitted.
- Reset mid-frame (at data bit 3), then with SHIFT_FRAME_TX_PARITY_EN defined send 0x07:
  - Reset edge -> tx_out=1, busy=0, no done.
  - 0x07 frame -> parity bit = 1 on edges 36..39; stop on edges 40..43; done at edge 44.
